// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store initiator: op codes, FSM states, op classifiers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_mem_master_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LHU = 3'd2,
        LSU_LB  = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_load(input lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
               (op == LSU_LB) || (op == LSU_LBU);
    endfunction

    // Sub-word stores need a read-modify-write because memory has no byte enables
    function automatic logic lsu_is_sub(input lsu_op_e op);
        return (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic logic lsu_is_word(input lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_is_half(input lsu_op_e op);
        return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Lane steering: load byte/half extraction with sign/zero extension, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are used.
module lsu_mem_master_lane_align
    import lsu_mem_master_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the read word
    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane for loads
    always_comb begin
        load_data = word;
        case (op)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'd0, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    // Replace only the addressed lane of the read word for sub-word stores
    always_comb begin
        merged = wdata;
        case (op)
            LSU_SB: begin
                merged = word;
                case (lane)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged[7:0] = wdata[7:0];
                endcase
            end
            LSU_SH: begin
                merged = word;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator to word-wide memory; optional misalignment check under LSU_ALIGN_CHECK_EN.
// Latency: loads/SW done 2 cycles after acceptance, SB/SH 3, out-of-range/misaligned 1.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_SPAN = 32'(MEM_WORDS * 4);

    lsu_state_e  state;
    lsu_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    lsu_op_e     op_in;
    logic [31:0] offset_in;
    logic        oor_in;
    logic        misaligned_in;

    assign op_in     = lsu_op_e'(req_op);
    assign offset_in = req_addr - MEM_BASE;
    assign oor_in    = (offset_in >= MEM_SPAN);

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned_in = (lsu_is_word(op_in) && (req_addr[1:0] != 2'b00)) ||
                           (lsu_is_half(op_in) && req_addr[0]);
`else
    assign misaligned_in = 1'b0;
`endif

    // A write strobe must never escape while reset is held, even from a WR cycle
    assign mem_we = we_q & ~rst;
    assign err    = err_q;

    lsu_mem_master_lane_align u_lane_align (
        .op        (op_q),
        .lane      (addr_q[1:0]),
        .word      (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Request FSM with registered handshake, strobe and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= 32'd0;
            we_q      <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            op_q      <= LSU_LW;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            pc_q      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_in;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        pc_q      <= req_pc;
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (misaligned_in) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err_q <= 1'b1;
                        end else if (oor_in) begin
                            // No memory cycle; loads return zero
                            state <= ST_DONE;
                            done  <= 1'b1;
                            if (lsu_is_load(op_in)) rdata <= 32'd0;
                        end else if (op_in == LSU_SW) begin
                            state     <= ST_WR;
                            we_q      <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (lsu_is_load(op_q)) begin
                        rdata <= load_data;
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        mem_wdata <= merged;
                        we_q      <= 1'b1;
                        state     <= ST_WR;
                    end
                end
                ST_WR: begin
                    we_q  <= 1'b0;
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    err_q     <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Store log, one line per committed memory write
    always_ff @(posedge clk) begin
        if (mem_we) $display("@%08h: *%08h <= %08h", pc_q, mem_addr, mem_wdata);
    end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a behavioural word memory.
// Latency: checks done timing per op class.
// Backpressure: issues one request at a time, waiting for done.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int nvec  = 0;
    int nfail = 0;
    int we_cnt = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'h4000) ? mem[mem_addr[13:2]] : 32'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    lsu_mem_master #(.MEM_BASE(32'h0), .MEM_WORDS(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from acceptance to done (99 if it never came)
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc, output int lat);
        int i;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 99;
        i = 1;
        while (i <= 8 && lat == 99) begin
            if (done) lat = i;
            else begin
                @(posedge clk); #1;
                i++;
            end
        end
    endtask

    int lat;
    int we0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // 1: SW then LW of the same word
        we0 = we_cnt;
        do_req(3'd5, 32'h10, 32'hDEADBEEF, 32'h100, lat);
        chk("sw_lat", lat, 2);
        chk("sw_ready_in_done", {31'd0, req_ready}, 32'd0);
        chk("sw_we_count", we_cnt - we0, 1);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        we0 = we_cnt;
        do_req(3'd0, 32'h10, 32'h0, 32'h104, lat);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_err", {31'd0, err}, 32'd0);
        chk("lw_no_we", we_cnt - we0, 0);

        // 2: SB merge into byte 1
        we0 = we_cnt;
        do_req(3'd7, 32'h11, 32'h1234565A, 32'h108, lat);
        chk("sb_lat", lat, 3);
        chk("sb_we_count", we_cnt - we0, 1);
        chk("sb_mem", mem[4], 32'hDEAD5AEF);

        // 3: extension cases on 0x80007F80
        do_req(3'd5, 32'h20, 32'h80007F80, 32'h10C, lat);
        do_req(3'd3, 32'h20, 32'h0, 32'h110, lat);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        do_req(3'd4, 32'h20, 32'h0, 32'h114, lat);
        chk("lbu_rdata", rdata, 32'h00000080);
        do_req(3'd1, 32'h22, 32'h0, 32'h118, lat);
        chk("lh_rdata", rdata, 32'hFFFF8000);
        chk("lh_lat", lat, 2);
        do_req(3'd2, 32'h22, 32'h0, 32'h11C, lat);
        chk("lhu_rdata", rdata, 32'h00008000);
        do_req(3'd6, 32'h22, 32'h5555ABCD, 32'h120, lat);
        chk("sh_lat", lat, 3);
        chk("sh_mem", mem[8], 32'hABCD7F80);

        // 4: out of range
        we0 = we_cnt;
        do_req(3'd5, 32'h4000, 32'hCAFEF00D, 32'h124, lat);
        chk("oor_sw_lat", lat, 1);
        chk("oor_sw_no_we", we_cnt - we0, 0);
        do_req(3'd0, 32'h4000, 32'h0, 32'h128, lat);
        chk("oor_lw_lat", lat, 1);
        chk("oor_lw_rdata", rdata, 32'd0);

        // 5: reset during the RD cycle of an SH
        do_req(3'd5, 32'h30, 32'h11112222, 32'h12C, lat);
        we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h30; req_wdata = 32'h9999; req_pc = 32'h130;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        chk("rstmid_we_in_rd", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_no_we", we_cnt - we0, 0);
        chk("rstmid_mem", mem[12], 32'h11112222);
        chk("rstmid_done_later", {31'd0, done}, 32'd0);

        // 6: misaligned word load
        do_req(3'd3, 32'h20, 32'h0, 32'h134, lat);
        we0 = we_cnt;
        do_req(3'd0, 32'h13, 32'h0, 32'h138, lat);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_lat", lat, 1);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_rdata_kept", rdata, 32'hFFFFFF80);
`else
        chk("mis_lat", lat, 2);
        chk("mis_err", {31'd0, err}, 32'd0);
        chk("mis_rdata", rdata, 32'hDEAD5AEF);
`endif
        chk("mis_no_we", we_cnt - we0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
